// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte).
package imem_loader_pkg;

    // Loader states; CSUM is only reachable with IMEM_LOADER_CHECKSUM_EN defined
    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    // Length prefix is LEN_LO then LEN_HI
    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WIDX_W    = 8;

    // Number of 32-bit words that fit in the instruction memory
    function automatic int unsigned max_words(input int unsigned imem_bytes);
        return imem_bytes / 4;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and registers the
// resulting word write (strobe, address, data) one cycle after lane 3.
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        in_byte,
    input  logic [WIDX_W-1:0] word_idx,
    output logic              last_lane_c,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data
);

    logic [1:0]        lane_q,    lane_d;
    logic [23:0]       sh_q,      sh_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    assign last_lane_c = (lane_q == 2'd3);
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

    // Lane counting, byte shifting and word-write generation
    always_comb begin
        lane_d    = lane_q;
        sh_d      = sh_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (clear) begin
            lane_d = 2'd0;
        end else if (accept) begin
            if (lane_q == 2'd3) begin
                wr_en_d   = 1'b1;
                wr_data_d = {in_byte, sh_q};
                wr_addr_d = ADDR_W'({word_idx, 2'b00});
                lane_d    = 2'd0;
            end else begin
                sh_d   = {in_byte, sh_q[23:8]};
                lane_d = lane_q + 2'd1;
            end
        end
    end

    // Packer state and registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q    <= 2'd0;
            sh_q      <= 24'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
        end else begin
            lane_q    <= lane_d;
            sh_q      <= sh_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed byte stream in,
// 32-bit word writes out, core held in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing mod-256 checksum).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned MAX_WORDS = max_words(IMEM_BYTES);
    localparam int unsigned LEN_W     = BYTE_W * HDR_BYTES;

    state_e            state_q,    state_d;
    logic [7:0]        len_lo_q,   len_lo_d;
    logic [LEN_W-1:0]  n_q,        n_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic              hold_q,     hold_d;
    logic              done_q,     done_d;
    logic              error_q,    error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q,     csum_d;
`endif

    logic             ready_c;
    logic             accept_c;
    logic             data_accept_c;
    logic             clear_c;
    logic             last_lane_c;
    logic [LEN_W-1:0] hdr_len_c;

    // Ready is a pure state decode, gated off while reset is asserted
    always_comb begin
        ready_c = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                  (state_q == ST_DATA)   || (state_q == ST_CSUM);
    end

    assign in_ready      = ready_c && !reset;
    assign accept_c      = in_valid && in_ready;
    assign data_accept_c = accept_c && (state_q == ST_DATA);
    assign clear_c       = reload && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign hdr_len_c     = LEN_W'({in_data, len_lo_q});

    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign error    = error_q;

    imem_word_packer #(
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear_c),
        .accept      (data_accept_c),
        .in_byte     (in_data),
        .word_idx    (word_idx_q),
        .last_lane_c (last_lane_c),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    // Next-state, word index, checksum and status output decode
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_LEN_LO: begin
                if (accept_c) begin
                    len_lo_d = in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept_c) begin
                    n_d = hdr_len_c;
                    if (32'(hdr_len_c) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (hdr_len_c == '0) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q + in_data;
`endif
                    if (last_lane_c) begin
                        word_idx_d = word_idx_q + WIDX_W'(1);
                        if ((LEN_W'(word_idx_q) + LEN_W'(1)) == n_q) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = ST_CSUM;
`else
                state_d = ST_DONE;
`endif
            end
            ST_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept_c) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
                end
`else
                state_d = ST_ERROR;
`endif
            end
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d    = ST_LEN_LO;
                    word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            default: state_d = ST_LEN_LO;
        endcase

        hold_d  = (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    // Loader state and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LEN_LO;
            len_lo_q   <= 8'd0;
            n_q        <= '0;
            word_idx_q <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's byte-addressed instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. Issues one word write per instruction to the instruction memory write port, holding the core in reset until the image is complete. Sits between the host/debug byte link and the instruction memory; the core's fetch path only reads memory after `cpu_hold` drops.

## Interface

Parameters:
- `IMEM_BYTES`, 256: instruction memory size in bytes; must be a multiple of 4.
- `ADDR_W`, 8: write address width; must satisfy 2^ADDR_W ≥ IMEM_BYTES.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte. A transfer occurs on a rising edge where `in_valid && in_ready`.
- `reload` input 1: restarts the load; honoured only in DONE or ERROR.
- `wr_en` output 1: one-cycle word-write strobe.
- `wr_addr` output ADDR_W: byte address of the word; always 4-aligned.
- `wr_data` output 32: `{b3,b2,b1,b0}`, where b0 is the first received byte.
- `cpu_hold` output 1: high whenever the state is not DONE.
- `done` output 1: high in DONE.
- `error` output 1: high in ERROR.

## Operation

Stream format:
- LEN_LO byte, then LEN_HI byte. Together they form a 16-bit word count N.
- Then 4·N instruction bytes.
- Then, only with the checksum feature enabled, one checksum byte.

States:
- **LEN_LO**: accept byte → LEN_HI.
- **LEN_HI**: accept byte, forming N.
  - N > IMEM_BYTES/4 → ERROR.
  - N = 0 → FLUSH (no writes).
  - Otherwise → DATA.
- **DATA**: accept bytes.
  - A 2-bit byte counter selects the lane.
  - On acceptance of lane 3, the word is registered, and `wr_en` pulses on the next cycle with `wr_addr` = word_idx·4.
  - word_idx then increments. Increments are 8-bit wide; the range check guarantees word_idx·4 never wraps.
  - After the lane-3 byte of word N−1 → FLUSH.
- **FLUSH**: `in_ready` = 0. Carries the final `wr_en` pulse if one is pending. → CSUM if the feature is enabled, else → DONE.
- **CSUM**: see Configuration.
- **DONE**: `in_ready` = 0, `cpu_hold` = 0, `done` = 1. `reload` → LEN_LO.
- **ERROR**: `in_ready` = 0, `cpu_hold` = 1, `error` = 1. `reload` → LEN_LO.
  - Any write already pending on entry still completes.

`reload` handling:
- In DONE or ERROR, it clears word_idx, the lane counter, and the checksum accumulator.
- In any other state it is ignored.

Reset values:
- State is LEN_LO; counters and checksum are 0.
- `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
- `cpu_hold` = 1, `done` = 0, `error` = 0.
- `in_ready` is forced 0 while `reset` is high. It is 1 in the first cycle after release.

Reset mid-load returns the block to LEN_LO. Memory words already written keep their values, and no partial word is written.

## Timing

- `in_ready` is decoded from the registered state only. It never depends on `in_valid`.
- One byte can be accepted per cycle; gaps in `in_valid` stall without losing state.
- Write latency is one cycle after acceptance of the lane-3 byte. `wr_addr` and `wr_data` are stable while `wr_en` = 1; afterwards they are don't-care.
- Minimum load time for N > 0 without checksum is 2 + 4N + 1 cycles to DONE.
- `cpu_hold` falls on the same edge that enters DONE. This is strictly after the last `wr_en` cycle, so memory is complete before fetch starts.

## Configuration

`IMEM_LOADER_CHECKSUM_EN`:
- **Defined:** CSUM state exists with `in_ready` = 1.
  - The accumulator is the 8-bit sum mod 256 of all instruction bytes; length bytes are excluded.
  - The received byte is compared against the accumulator: equal → DONE, else → ERROR.
  - For N = 0, the expected checksum is 0x00.
- **Undefined:** no accumulator and no CSUM state; FLUSH → DONE.

## Structure

- `imem_loader_pkg` holds:
  - the state enum (LEN_LO, LEN_HI, DATA, FLUSH, CSUM, DONE, ERROR);
  - the header byte-count constant (2);
  - the `MAX_WORDS = IMEM_BYTES/4` helper.
- One sub-module, `imem_word_packer`, holds:
  - the lane counter and the 4×8 byte shift/assembly;
  - the registered `wr_en`/`wr_data` outputs.
- The FSM, word index and checksum stay in the top.

## Test plan

- Header 02 00, bytes 13 05 00 10 93 05 40 00, `in_valid` continuous:
  - `wr_en` pulses twice: addr 0x00 data 0x10000513, then addr 0x04 data 0x00400593.
  - `done` = 1 and `cpu_hold` = 0 eleven cycles after the first byte is accepted.
- The same image with `in_valid` dropped for 3 cycles after every byte: identical writes and final state, and no extra `wr_en` pulses.
- Header 41 00 (N = 65, above 64): `error` = 1 after LEN_HI, no `wr_en` pulses, `in_ready` = 0, `cpu_hold` stays 1.
- Header 00 00: no writes and `done` = 1. With the checksum feature enabled, a checksum byte of 0x00 is also required.
- Checksum feature enabled:
  - The 2-word image followed by checksum 0x00 → DONE.
  - The same image followed by 0x01 → ERROR; both writes still occurred.
  - `reload` then restarts from LEN_LO.
- `reset` asserted asynchronously after 5 data bytes:
  - All outputs return to reset values immediately, and the pending lane-1 byte is discarded.
  - A full reload then writes correct words starting at addr 0x00.
